// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the MIPS multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    MDU_OP_MULT  = 3'b000,
    MDU_OP_MULTU = 3'b001,
    MDU_OP_DIV   = 3'b010,
    MDU_OP_DIVU  = 3'b011,
    MDU_OP_MTHI  = 3'b100,
    MDU_OP_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; used for operand abs and result sign fix.
module mdu_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_val,
  input  logic             negate,
  output logic [WIDTH-1:0] out_val
);

  always_comb begin
    out_val = in_val;
    if (negate) out_val = ~in_val + WIDTH'(1);
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Magnitudes are processed one bit per cycle, signs are re-applied in FIX.
module mips_muldiv_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MDU_WIDTH = MDU_WIDTH_DEFAULT
) (
  input  logic                 MDU_clk,
  input  logic                 MDU_reset,
  input  logic                 MDU_start,
  input  logic [2:0]           MDU_op,
  input  logic [MDU_WIDTH-1:0] MDU_rs,
  input  logic [MDU_WIDTH-1:0] MDU_rt,
  output logic                 MDU_busy,
  output logic                 MDU_done,
  output logic [MDU_WIDTH-1:0] MDU_hi,
  output logic [MDU_WIDTH-1:0] MDU_lo
);

  localparam int unsigned W     = MDU_WIDTH;
  localparam int unsigned CNT_W = $clog2(MDU_WIDTH) + 1;

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]     acc_q, acc_d;
  logic [W-1:0]       opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [W-1:0]       hi_q, hi_d;
  logic [W-1:0]       lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               op_signed;
  logic [W-1:0]       abs_rs, abs_rt;
  logic [2*W-1:0]     prod_fix;
  logic [W-1:0]       quo_fix, rem_fix;
  logic [W:0]         mul_sum;
  logic [W:0]         div_shift;
  logic               div_ge;
  logic [W-1:0]       div_sub;

  assign op_signed = ~MDU_op[0];

  mdu_sign_fix #(.WIDTH(W)) u_abs_rs (
    .in_val (MDU_rs),
    .negate (op_signed & MDU_rs[W-1]),
    .out_val(abs_rs)
  );

  mdu_sign_fix #(.WIDTH(W)) u_abs_rt (
    .in_val (MDU_rt),
    .negate (op_signed & MDU_rt[W-1]),
    .out_val(abs_rt)
  );

  mdu_sign_fix #(.WIDTH(2*W)) u_fix_prod (
    .in_val (acc_q),
    .negate (neg_res_q),
    .out_val(prod_fix)
  );

  mdu_sign_fix #(.WIDTH(W)) u_fix_quo (
    .in_val (acc_q[W-1:0]),
    .negate (neg_res_q),
    .out_val(quo_fix)
  );

  mdu_sign_fix #(.WIDTH(W)) u_fix_rem (
    .in_val (acc_q[2*W-1:W]),
    .negate (neg_rem_q),
    .out_val(rem_fix)
  );

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  // Divide: acc = {remainder, dividend/quotient bits}, shifted left.
  assign div_shift = acc_q[2*W-1:W-1];
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_sub   = div_shift[W-1:0] - opnd_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (MDU_start) begin
          case (MDU_op)
            MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU: begin
              is_div_d  = MDU_op[1];
              neg_res_d = op_signed & (MDU_rs[W-1] ^ MDU_rt[W-1]);
              neg_rem_d = op_signed & MDU_rs[W-1];
              div0_d    = MDU_op[1] & (MDU_rt == '0);
              opnd_d    = MDU_op[1] ? abs_rt : abs_rs;
              acc_d     = {{W{1'b0}}, (MDU_op[1] ? abs_rs : abs_rt)};
              cnt_d     = '0;
              busy_d    = 1'b1;
              state_d   = CALC;
            end
            MDU_OP_MTHI: hi_d = MDU_rs;
            MDU_OP_MTLO: lo_d = MDU_rs;
            default: ;
          endcase
        end
      end
      CALC: begin
        if (is_div_q) acc_d = {(div_ge ? div_sub : div_shift[W-1:0]), acc_q[W-2:0], div_ge};
        else          acc_d = {mul_sum, acc_q[W-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          // Remainder fix alone restores rs on divide-by-zero; only LO needs forcing.
          hi_d = rem_fix;
          lo_d = div0_q ? '1 : quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MDU_clk) begin
    if (MDU_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign MDU_busy = busy_q;
  assign MDU_done = done_q;
  assign MDU_hi   = hi_q;
  assign MDU_lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench: cycle-level reference model plus directed literal checks.
module tb_mips_muldiv_unit;
  import mdu_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = 3'b110;
  logic [W-1:0]  rs = '0;
  logic [W-1:0]  rt = '0;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  mips_muldiv_unit #(.MDU_WIDTH(W)) dut (
    .MDU_clk  (clk),
    .MDU_reset(rst),
    .MDU_start(start),
    .MDU_op   (op),
    .MDU_rs   (rs),
    .MDU_rt   (rt),
    .MDU_busy (busy),
    .MDU_done (done),
    .MDU_hi   (hi),
    .MDU_lo   (lo)
  );

  always #5 clk = ~clk;

  // Architectural result {HI, LO} from plain arithmetic.
  function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] r, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (o)
      MDU_OP_MULT:  r = sa * sb;
      MDU_OP_MULTU: r = {32'b0, a} * {32'b0, b};
      MDU_OP_DIVU:  r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      MDU_OP_DIV: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          qv = sq;
          rv = sr;
          r  = {rv[31:0], qv[31:0]};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  logic          m_busy, m_done;
  logic [W-1:0]  m_hi, m_lo, p_hi, p_lo;
  int            m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
        end
      end else if (start) begin
        if (op <= 3'b011) begin
          {p_hi, p_lo} = model_res(op, rs, rt);
          m_busy = 1'b1;
          m_cnt  = LAT - 1;
        end else if (op == MDU_OP_MTHI) m_hi = rs;
        else if (op == MDU_OP_MTLO) m_lo = rs;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
      check("cyc_done", {31'b0, done}, {31'b0, m_done});
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
    end
  end

  // Caller is at a negedge; start is held for exactly one cycle.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0; op = 3'b110;
  endtask

  task automatic wait_done(input string name, input int n0, input int exp_n);
    int n;
    n = n0;
    while (done !== 1'b1 && n <= 200) begin
      @(negedge clk);
      n++;
    end
    if (n > 200) check({name, "_timeout"}, 32'd0, 32'd1);
    else         check({name, "_latency"}, n, exp_n);
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    @(negedge clk);
    issue(o, a, b);
    wait_done(name, 1, LAT);
    check({name, "_hi"}, hi, ehi);
    check({name, "_lo"}, lo, elo);
  endtask

  initial begin
    int saw_done;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    issue(MDU_OP_MTHI, 32'hDEAD_0000, 32'd0);
    check("mthi_idle", hi, 32'hDEAD_0000);
    issue(MDU_OP_MTLO, 32'h0000_BEEF, 32'd0);
    check("mtlo_idle", lo, 32'h0000_BEEF);

    // Reset in cycle 10 of a MULT.
    issue(MDU_OP_MULT, 32'd5, 32'd5);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    check("midrst_no_done", saw_done, 32'd0);

    run_op("mult_7_m3", MDU_OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu_max", MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg_neg", MDU_OP_MULT, 32'hFFFF_FFF6, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0032);
    run_op("divu_100_7", MDU_OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_m7_2", MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2", MDU_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_ovf", MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("div_m5_0", MDU_OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // DIVU by zero with an MTHI attempted while busy.
    @(negedge clk);
    issue(MDU_OP_DIVU, 32'h0000_1234, 32'd0);
    issue(MDU_OP_MTHI, 32'hAAAA_0000, 32'd0);
    wait_done("divu_by0", 2, LAT);
    check("divu_by0_hi", hi, 32'h0000_1234);
    check("divu_by0_lo", lo, 32'hFFFF_FFFF);
    issue(MDU_OP_MTLO, 32'h0000_5555, 32'd0);
    check("mtlo_lo", lo, 32'h0000_5555);
    check("mtlo_hi", hi, 32'h0000_1234);
    check("mtlo_no_done", {31'b0, done}, 32'd0);

    // MULT issued in the done cycle of a DIVU.
    @(negedge clk);
    issue(MDU_OP_DIVU, 32'd100, 32'd7);
    wait_done("b2b_divu", 1, LAT);
    check("b2b_divu_hi", hi, 32'd2);
    check("b2b_divu_lo", lo, 32'd14);
    issue(MDU_OP_MULT, 32'd2, 32'd3);
    check("b2b_busy", {31'b0, busy}, 32'd1);
    check("b2b_hold_hi", hi, 32'd2);
    check("b2b_hold_lo", lo, 32'd14);
    wait_done("b2b_mult", 1, LAT);
    check("b2b_mult_hi", hi, 32'd0);
    check("b2b_mult_lo", lo, 32'd6);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
